aes_block_sequencer: RTL and testbench
======================================

AES_BLOCK_SEQUENCER -- requirements
Module: aes_block_sequencer

Interface
REQ-001 Parameter DEPTH, 4, input FIFO depth in 128-bit blocks; power of two, minimum 2.
REQ-002 Parameter KEY_W, 256, key width; legal values 128, 192, 256.
REQ-003 Parameter CNT_W, 16, width of the completed-block counter.
REQ-004 Port clk_i, in, 1, single clock; all logic on the rising edge.
REQ-005 Port rst_ni, in, 1, reset, synchronous and active-low.
REQ-006 Ports in_data_i in 128, in_valid_i in 1, in_ready_o out 1: plaintext/ciphertext block stream.
REQ-007 Ports key_i in KEY_W, key_valid_i in 1: key load strobe.
REQ-008 Ports iv_i in 128, iv_valid_i in 1: CBC IV load strobe.
REQ-009 Ports mode_cbc_i in 1 (0=ECB, 1=CBC), decrypt_i in 1 (0=encrypt, 1=decrypt).
REQ-010 Ports core_ready_i in 1, core_start_o out 1, core_decrypt_o out 1, core_key_o out KEY_W, core_data_o out 128: AES core request side.
REQ-011 Ports core_done_i in 1, core_result_i in 128: AES core completion side.
REQ-012 Ports out_data_o out 128, out_valid_o out 1, out_ready_i in 1: result stream.
REQ-013 Ports busy_o out 1, cfg_err_o out 1, blk_count_o out CNT_W: status outputs.

Function
REQ-014 Input FIFO SHALL accept a block when in_valid_i and in_ready_o are both high; in_ready_o SHALL be low when the FIFO is full, with no same-cycle pass-through at full.
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, OUTPUT.
REQ-016 IDLE -> ISSUE when the FIFO is not empty and core_ready_i is high; on this transition the head block is popped and mode_cbc_i/decrypt_i are latched for that block.
REQ-017 ISSUE SHALL assert core_start_o for exactly one cycle, then go to WAIT.
REQ-018 WAIT SHALL hold until core_done_i is high, capture the result into the output register, then go to OUTPUT; core_done_i seen outside WAIT SHALL be ignored.
REQ-019 OUTPUT SHALL hold out_valid_o high and out_data_o stable until out_ready_i is high, then go to IDLE; blk_count_o increments on that handshake and wraps modulo 2^CNT_W.
REQ-020 ECB: core_data_o = block; output = core_result_i.
REQ-021 CBC encrypt: core_data_o = block XOR chain; output = core_result_i; chain <= core_result_i.
REQ-022 CBC decrypt: core_data_o = block; output = core_result_i XOR chain; chain <= the popped ciphertext block.
REQ-023 The chain register SHALL be loaded from iv_i on an accepted iv_valid_i and updated only in CBC mode.
REQ-024 key_valid_i and iv_valid_i SHALL be accepted only in IDLE with an empty FIFO; otherwise the update is dropped and cfg_err_o pulses high for one cycle.
REQ-025 core_key_o SHALL drive the key register; core_decrypt_o SHALL drive the latched decrypt bit.
REQ-026 busy_o SHALL be high whenever the state is not IDLE or the FIFO is not empty.
REQ-027 Minimum per-block latency from pop to out_valid_o SHALL be core latency + 2 cycles.

Reset
REQ-028 On rst_ni low at a clock edge: state IDLE, FIFO empty, in_ready_o 1, core_start_o 0, out_valid_o 0, out_data_o 0, key 0, chain 0, blk_count_o 0, cfg_err_o 0, busy_o 0.
REQ-029 Reset mid-operation SHALL abandon the in-flight block; a late core_done_i after reset SHALL be ignored.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration and the AES block width constant of 128.
REQ-031 The input FIFO SHALL be one sub-module, blk_fifo, parametrised by width and depth.

Verification
REQ-032 ECB encrypt: key 000102..1f, block 00112233445566778899aabbccddeeff, behavioural AES core model -> out_data_o 8ea2b7ca516745bfeafc49904b496089; blk_count_o 1.
REQ-033 CBC encrypt: IV 000..01, same block -> core_data_o 00112233445566778899aabbccddeeff XOR IV; a second block is XORed with the first result.
REQ-034 CBC decrypt of the REQ-033 ciphertexts -> both original plaintexts recovered in order.
REQ-035 DEPTH=4, out_ready_i held low, 6 blocks pushed -> in_ready_o low after 4 are stored plus 1 in flight; all 6 emerge in order once released.
REQ-036 key_valid_i pulsed during WAIT -> cfg_err_o high for 1 cycle; key unchanged.
REQ-037 rst_ni low during WAIT, then core_done_i -> out_valid_o stays 0; blk_count_o 0.

Source files
------------

// File: rtl/aes_block_sequencer_pkg.sv
// Shared types and helpers for the AES block sequencer: FSM states, block
// width, and the per-mode chaining arithmetic used around the AES core.
package aes_block_sequencer_pkg;

  localparam int BLK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;

  typedef struct packed {
    logic cbc;
    logic dec;
  } blk_mode_t;

  // Only CBC encrypt folds the chain into the core input.
  function automatic logic [BLK_W-1:0] core_input(input blk_mode_t mode,
                                                  input logic [BLK_W-1:0] blk,
                                                  input logic [BLK_W-1:0] chain);
    return (mode.cbc && !mode.dec) ? (blk ^ chain) : blk;
  endfunction

  // Only CBC decrypt folds the chain into the core output.
  function automatic logic [BLK_W-1:0] result_output(input blk_mode_t mode,
                                                     input logic [BLK_W-1:0] res,
                                                     input logic [BLK_W-1:0] chain);
    return (mode.cbc && mode.dec) ? (res ^ chain) : res;
  endfunction

  function automatic logic [BLK_W-1:0] next_chain(input blk_mode_t mode,
                                                  input logic [BLK_W-1:0] blk,
                                                  input logic [BLK_W-1:0] res,
                                                  input logic [BLK_W-1:0] chain);
    if (!mode.cbc) return chain;
    return mode.dec ? blk : res;
  endfunction

endpackage

// File: rtl/aes_block_sequencer_blk_fifo.sv
// Synchronous FIFO for input blocks. Full/empty come from wrap-bit pointers,
// so no pass-through at full: a push is only taken when a slot is free.
module blk_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign full_o     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty_o    = (r_wr_ptr == r_rd_ptr);
  assign w_push     = push_i && !full_o;
  assign w_pop      = pop_i && !empty_o;
  assign pop_data_o = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/aes_block_sequencer.sv
// Sequences 128-bit blocks from an input FIFO through an external AES core,
// applying ECB/CBC chaining, and presents each result on a valid/ready port.
module aes_block_sequencer
  import aes_block_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,    // power of two, >= 2
  parameter int KEY_W = 256,  // 128, 192 or 256
  parameter int CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [BLK_W-1:0]   in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [KEY_W-1:0]   key_i,
  input  logic               key_valid_i,
  input  logic [BLK_W-1:0]   iv_i,
  input  logic               iv_valid_i,
  input  logic               mode_cbc_i,
  input  logic               decrypt_i,
  input  logic               core_ready_i,
  output logic               core_start_o,
  output logic               core_decrypt_o,
  output logic [KEY_W-1:0]   core_key_o,
  output logic [BLK_W-1:0]   core_data_o,
  input  logic               core_done_i,
  input  logic [BLK_W-1:0]   core_result_i,
  output logic [BLK_W-1:0]   out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               busy_o,
  output logic               cfg_err_o,
  output logic [CNT_W-1:0]   blk_count_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  state_e           w_state_next;
  blk_mode_t        r_mode;
  blk_mode_t        w_mode_in;
  logic [BLK_W-1:0] r_blk;
  logic [BLK_W-1:0] r_core_data;
  logic [BLK_W-1:0] r_chain;
  logic [BLK_W-1:0] r_out_data;
  logic [KEY_W-1:0] r_key;
  logic [CNT_W-1:0] r_blk_count;
  logic             r_cfg_err;

  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [BLK_W-1:0] w_head;
  logic             w_pop;
  logic             w_capture;
  logic             w_out_hs;
  logic             w_cfg_ok;
  logic             w_cfg_req;

  assign w_mode_in = '{cbc: mode_cbc_i, dec: decrypt_i};

  blk_fifo #(
    .WIDTH (BLK_W),
    .DEPTH (DEPTH)
  ) u_blk_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (in_valid_i),
    .push_data_i (in_data_i),
    .full_o      (w_fifo_full),
    .pop_i       (w_pop),
    .pop_data_o  (w_head),
    .empty_o     (w_fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_out_hs     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty && core_ready_i) begin
          w_pop        = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (core_done_i) begin
          w_capture    = 1'b1;
          w_state_next = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (out_ready_i) begin
          w_out_hs     = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Key/IV may only change while nothing is queued or in flight.
  assign w_cfg_ok  = (r_state == ST_IDLE) && w_fifo_empty;
  assign w_cfg_req = key_valid_i || iv_valid_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_blk       <= '0;
      r_mode      <= '0;
      r_core_data <= '0;
    end else if (w_pop) begin
      r_blk       <= w_head;
      r_mode      <= w_mode_in;
      r_core_data <= core_input(w_mode_in, w_head, r_chain);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_chain     <= '0;
      r_out_data  <= '0;
      r_key       <= '0;
      r_blk_count <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      if (w_cfg_ok && iv_valid_i) r_chain <= iv_i;
      else if (w_capture)         r_chain <= next_chain(r_mode, r_blk, core_result_i, r_chain);
      if (w_capture)              r_out_data <= result_output(r_mode, core_result_i, r_chain);
      if (w_cfg_ok && key_valid_i) r_key <= key_i;
      if (w_out_hs)               r_blk_count <= r_blk_count + CNT_ONE;
      r_cfg_err <= w_cfg_req && !w_cfg_ok;
    end
  end

  assign in_ready_o     = !w_fifo_full;
  assign core_start_o   = (r_state == ST_ISSUE);
  assign core_decrypt_o = r_mode.dec;
  assign core_key_o     = r_key;
  assign core_data_o    = r_core_data;
  assign out_data_o     = r_out_data;
  assign out_valid_o    = (r_state == ST_OUTPUT);
  assign busy_o         = (r_state != ST_IDLE) || !w_fifo_empty;
  assign cfg_err_o      = r_cfg_err;
  assign blk_count_o    = r_blk_count;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Self-checking bench for aes_block_sequencer: directed vectors, a queue-based
// chaining model under random stimulus, and hand-written corner sequences.
module tb_aes_block_sequencer;

  localparam int DEPTH   = 4;
  localparam int KEY_W   = 256;
  localparam int CNT_W   = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  localparam logic [255:0] KEY_REF = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_REF  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_REF  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_TWO  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] IV_REF  = 128'h1;
  localparam logic [127:0] MIX_C   = 128'hc3a55a3c0ff0e11e96695aa5d22d4bb4;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic [127:0]       in_data_i = '0;
  logic               in_valid_i = 1'b0;
  logic               in_ready_o;
  logic [KEY_W-1:0]   key_i = '0;
  logic               key_valid_i = 1'b0;
  logic [127:0]       iv_i = '0;
  logic               iv_valid_i = 1'b0;
  logic               mode_cbc_i = 1'b0;
  logic               decrypt_i = 1'b0;
  logic               core_ready_i = 1'b1;
  logic               core_start_o;
  logic               core_decrypt_o;
  logic [KEY_W-1:0]   core_key_o;
  logic [127:0]       core_data_o;
  logic               core_done_i;
  logic [127:0]       core_result_i = '0;
  logic [127:0]       out_data_o;
  logic               out_valid_o;
  logic               out_ready_i = 1'b0;
  logic               busy_o;
  logic               cfg_err_o;
  logic [CNT_W-1:0]   blk_count_o;

  aes_block_sequencer #(.DEPTH(DEPTH), .KEY_W(KEY_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .key_i(key_i), .key_valid_i(key_valid_i),
    .iv_i(iv_i), .iv_valid_i(iv_valid_i),
    .mode_cbc_i(mode_cbc_i), .decrypt_i(decrypt_i),
    .core_ready_i(core_ready_i), .core_start_o(core_start_o),
    .core_decrypt_o(core_decrypt_o), .core_key_o(core_key_o), .core_data_o(core_data_o),
    .core_done_i(core_done_i), .core_result_i(core_result_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .busy_o(busy_o), .cfg_err_o(cfg_err_o), .blk_count_o(blk_count_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  int accepted = 0;
  logic [127:0] last_out = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in AES core: an invertible keyed mix, patched so the published
  // AES-256 vector (KEY_REF, PT_REF) -> CT_REF maps exactly, both directions.
  function automatic logic [127:0] mix_fwd(input logic [127:0] x, input logic [255:0] k);
    logic [127:0] y;
    y = x ^ k[127:0];
    y = {y[118:0], y[127:119]};
    y = y + (k[255:128] | 128'h1);
    return y ^ MIX_C;
  endfunction

  function automatic logic [127:0] mix_inv(input logic [127:0] x, input logic [255:0] k);
    logic [127:0] y;
    y = x ^ MIX_C;
    y = y - (k[255:128] | 128'h1);
    y = {y[8:0], y[127:9]};
    return y ^ k[127:0];
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] x, input logic [255:0] k);
    if (k == KEY_REF && x == PT_REF) return CT_REF;
    if (k == KEY_REF && x == mix_inv(CT_REF, k)) return mix_fwd(PT_REF, k);
    return mix_fwd(x, k);
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] y, input logic [255:0] k);
    if (k == KEY_REF && y == CT_REF) return PT_REF;
    if (k == KEY_REF && y == mix_fwd(PT_REF, k)) return mix_inv(CT_REF, k);
    return mix_inv(y, k);
  endfunction

  int           core_lat = 1;
  bit           rand_ready = 1'b0;
  logic         model_done = 1'b0;
  logic         spur_done = 1'b0;
  logic         m_busy = 1'b0;
  int           m_cnt = 0;
  logic [127:0] m_res = '0;
  logic [127:0] cap_data = '0;
  int           n_starts = 0;

  assign core_done_i = model_done | spur_done;

  // Core model ignores the sequencer's reset, so an abandoned job still
  // completes afterwards, like a real core on a separate reset domain.
  always @(negedge clk_i) begin
    model_done = 1'b0;
    if (m_busy) begin
      if (m_cnt <= 1) begin
        model_done    = 1'b1;
        core_result_i = m_res;
        m_busy        = 1'b0;
      end else m_cnt--;
    end
    if (core_start_o) begin
      m_busy   = 1'b1;
      m_cnt    = core_lat;
      cap_data = core_data_o;
      n_starts++;
      m_res = core_decrypt_o ? aes_dec(core_data_o, core_key_o) : aes_enc(core_data_o, core_key_o);
    end
    core_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic cfg_load(input bit is_key, input logic [255:0] val, input bit expect_err);
    @(negedge clk_i);
    if (is_key) begin key_i = val; key_valid_i = 1'b1; end
    else begin iv_i = val[127:0]; iv_valid_i = 1'b1; end
    @(negedge clk_i);
    key_valid_i = 1'b0;
    iv_valid_i  = 1'b0;
    check(is_key ? "cfg_err after key" : "cfg_err after iv", 256'(cfg_err_o), 256'(expect_err));
  endtask

  task automatic push(input logic [127:0] b);
    bit ok;
    int guard;
    in_data_i  = b;
    in_valid_i = 1'b1;
    guard = 0;
    do begin
      ok = in_ready_o;
      @(negedge clk_i);
      guard++;
    end while (!ok && guard < 300);
    in_valid_i = 1'b0;
    if (!ok) check("push timeout", 256'(0), 256'(1));
  endtask

  task automatic pull(input logic [127:0] exp, input string name);
    int guard;
    guard = 0;
    while (!out_valid_o && guard < 300) begin
      @(negedge clk_i);
      guard++;
    end
    if (!out_valid_o) begin
      check({name, " timeout"}, 256'(0), 256'(1));
      return;
    end
    check(name, 256'(out_data_o), 256'(exp));
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    exp_cnt++;
    last_out = exp;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy_o && guard < 300) begin
      @(negedge clk_i);
      guard++;
    end
    if (busy_o) check("idle timeout", 256'(0), 256'(1));
  endtask

  task automatic wait_start(input int s0);
    int guard;
    guard = 0;
    while (n_starts == s0 && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    if (n_starts == s0) check("core start timeout", 256'(0), 256'(1));
  endtask

  task automatic run_random(input bit cbc, input bit dec, input int n, input int lat);
    logic [255:0] k;
    logic [127:0] iv;
    logic [127:0] chain;
    logic [127:0] expq[$];
    wait_idle();
    k  = {$urandom(), $urandom(), $urandom(), $urandom(),
          $urandom(), $urandom(), $urandom(), $urandom()};
    iv = {$urandom(), $urandom(), $urandom(), $urandom()};
    cfg_load(1'b1, k, 1'b0);
    cfg_load(1'b0, 256'(iv), 1'b0);
    mode_cbc_i = cbc;
    decrypt_i  = dec;
    core_lat   = lat;
    rand_ready = 1'b1;
    chain      = iv;
    fork
      begin : producer
        logic [127:0] b;
        logic [127:0] e;
        for (int i = 0; i < n; i++) begin
          b = {$urandom(), $urandom(), $urandom(), $urandom()};
          if (!cbc)     e = dec ? aes_dec(b, k) : aes_enc(b, k);
          else if (!dec) begin e = aes_enc(b ^ chain, k); chain = e; end
          else          begin e = aes_dec(b, k) ^ chain; chain = b; end
          expq.push_back(e);
          push(b);
          repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end
      end
      begin : consumer
        int got;
        int guard;
        bit r;
        bit held;
        logic [127:0] hold_d;
        got = 0; guard = 0; held = 1'b0; hold_d = '0;
        while (got < n && guard < 5000) begin
          r = ($urandom_range(0, 2) != 0);
          if (held) begin
            check("stall valid held", 256'(out_valid_o), 256'(1));
            check("stall data held", 256'(out_data_o), 256'(hold_d));
            held = 1'b0;
          end
          if (out_valid_o) begin
            if (r) begin
              check($sformatf("rand out cbc=%0d dec=%0d #%0d", cbc, dec, got),
                    256'(out_data_o), 256'(expq.pop_front()));
              got++;
              exp_cnt++;
            end else begin
              held   = 1'b1;
              hold_d = out_data_o;
            end
          end
          out_ready_i = r;
          @(negedge clk_i);
          guard++;
        end
        out_ready_i = 1'b0;
        if (got < n) check("drain timeout", 256'(got), 256'(n));
      end
    join
    rand_ready = 1'b0;
    check("blk_count after random phase", 256'(blk_count_o), 256'(exp_cnt % CNT_MOD));
  endtask

  typedef struct {
    bit           load_iv;
    logic [127:0] iv;
    bit           cbc;
    bit           dec;
    logic [127:0] blk;
    logic [127:0] exp_core;
    logic [127:0] exp_out;
  } vec_t;

  initial begin
    vec_t vt[5];
    logic [127:0] c1;
    logic [127:0] c2;
    logic [127:0] bp_blk[6];
    bit seen_valid;
    int s0;

    c1 = aes_enc(PT_REF ^ IV_REF, KEY_REF);
    c2 = aes_enc(PT_TWO ^ c1, KEY_REF);
    vt[0] = '{1'b0, 128'h0,  1'b0, 1'b0, PT_REF, PT_REF,          CT_REF};
    vt[1] = '{1'b1, IV_REF,  1'b1, 1'b0, PT_REF, PT_REF ^ IV_REF, c1};
    vt[2] = '{1'b0, 128'h0,  1'b1, 1'b0, PT_TWO, PT_TWO ^ c1,     c2};
    vt[3] = '{1'b1, IV_REF,  1'b1, 1'b1, c1,     c1,              PT_REF};
    vt[4] = '{1'b0, 128'h0,  1'b1, 1'b1, c2,     c2,              PT_TWO};

    repeat (3) @(negedge clk_i);
    check("reset in_ready", 256'(in_ready_o), 256'(1));
    check("reset core_start", 256'(core_start_o), 256'(0));
    check("reset out_valid", 256'(out_valid_o), 256'(0));
    check("reset out_data", 256'(out_data_o), 256'(0));
    check("reset core_key", 256'(core_key_o), 256'(0));
    check("reset blk_count", 256'(blk_count_o), 256'(0));
    check("reset cfg_err", 256'(cfg_err_o), 256'(0));
    check("reset busy", 256'(busy_o), 256'(0));
    rst_ni = 1'b1;

    cfg_load(1'b1, KEY_REF, 1'b0);
    check("key loaded", 256'(core_key_o), KEY_REF);
    for (int i = 0; i < 5; i++) begin
      if (vt[i].load_iv) cfg_load(1'b0, 256'(vt[i].iv), 1'b0);
      mode_cbc_i = vt[i].cbc;
      decrypt_i  = vt[i].dec;
      push(vt[i].blk);
      pull(vt[i].exp_out, $sformatf("vec%0d out_data", i));
      check($sformatf("vec%0d core_data", i), 256'(cap_data), 256'(vt[i].exp_core));
      check($sformatf("vec%0d blk_count", i), 256'(blk_count_o), 256'(exp_cnt % CNT_MOD));
    end

    run_random(1'b0, 1'b0, 12, 1);
    run_random(1'b0, 1'b1, 12, 3);
    run_random(1'b1, 1'b0, 12, 2);
    run_random(1'b1, 1'b1, 12, 4);

    // Backpressure: one block in flight plus DEPTH stored, sixth must wait.
    wait_idle();
    cfg_load(1'b1, KEY_REF, 1'b0);
    mode_cbc_i = 1'b0;
    decrypt_i  = 1'b0;
    core_lat   = 2;
    accepted   = 0;
    for (int i = 0; i < 6; i++) bp_blk[i] = {$urandom(), $urandom(), $urandom(), 32'(i)};
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          push(bp_blk[i]);
          accepted++;
        end
      end
      begin
        repeat (25) @(negedge clk_i);
        check("bp accepted while stalled", 256'(accepted), 256'(5));
        check("bp in_ready when full", 256'(in_ready_o), 256'(0));
        check("bp busy", 256'(busy_o), 256'(1));
        for (int i = 0; i < 6; i++) pull(aes_enc(bp_blk[i], KEY_REF), $sformatf("bp out%0d", i));
      end
    join
    check("bp blk_count", 256'(blk_count_o), 256'(exp_cnt % CNT_MOD));

    // Key strobe while the core is busy must be rejected with a 1-cycle error.
    wait_idle();
    core_lat = 8;
    s0 = n_starts;
    push(PT_TWO);
    wait_start(s0);
    cfg_load(1'b1, ~KEY_REF, 1'b1);
    @(negedge clk_i);
    check("cfg_err one cycle", 256'(cfg_err_o), 256'(0));
    check("key kept after reject", 256'(core_key_o), KEY_REF);
    pull(aes_enc(PT_TWO, KEY_REF), "out after rejected key");

    // Done outside WAIT must not produce an output.
    wait_idle();
    @(negedge clk_i);
    spur_done = 1'b1;
    @(negedge clk_i);
    spur_done = 1'b0;
    @(negedge clk_i);
    check("spurious done out_valid", 256'(out_valid_o), 256'(0));
    check("spurious done out_data", 256'(out_data_o), 256'(last_out));
    check("spurious done busy", 256'(busy_o), 256'(0));

    // Reset during WAIT abandons the block; the late done is ignored.
    core_lat = 6;
    s0 = n_starts;
    push(PT_REF);
    wait_start(s0);
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    exp_cnt = 0;
    seen_valid = 1'b0;
    repeat (12) begin
      @(negedge clk_i);
      seen_valid |= out_valid_o;
    end
    check("reset mid-op out_valid", 256'(seen_valid), 256'(0));
    check("reset mid-op blk_count", 256'(blk_count_o), 256'(0));
    check("reset mid-op busy", 256'(busy_o), 256'(0));
    check("reset mid-op out_data", 256'(out_data_o), 256'(0));
    check("reset mid-op key", 256'(core_key_o), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
